// File: rtl/mem_native_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_native_arbiter
// Brief    : Round-robin arbiter sharing one native memory port between
//            NUM_MASTERS requesters, with a watchdog for silent slaves.
// Revision : 1.0
// ============================================================================
module mem_native_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                                                   clk,
  input  logic                                                   resetn,
  input  logic [NUM_MASTERS-1:0]                                 m_valid,
  input  logic [NUM_MASTERS-1:0]                                 m_instr,
  input  logic [32*NUM_MASTERS-1:0]                              m_addr,
  input  logic [32*NUM_MASTERS-1:0]                              m_wdata,
  input  logic [4*NUM_MASTERS-1:0]                               m_wstrb,
  output logic [NUM_MASTERS-1:0]                                 m_ready,
  output logic [31:0]                                            m_rdata,
  output logic                                                   s_valid,
  output logic                                                   s_instr,
  output logic [31:0]                                            s_addr,
  output logic [31:0]                                            s_wdata,
  output logic [3:0]                                             s_wstrb,
  input  logic                                                   s_ready,
  input  logic [31:0]                                            s_rdata,
  output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] grant,
  output logic                                                   timeout_err
);

  localparam int          c_GW           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int          c_CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [c_GW-1:0]   r_grant;
  logic [c_GW-1:0]   r_ptr;
  logic [c_GW-1:0]   w_sel;
  logic [c_GW-1:0]   w_ptr_nxt;
  logic              w_found;
  logic              w_busy;
  logic              w_done;
  logic              w_wd_hit;

  logic              r_s_instr;
  logic [31:0]       r_s_addr;
  logic [31:0]       r_s_wdata;
  logic [3:0]        r_s_wstrb;

  logic [31:0]       w_addr  [NUM_MASTERS];
  logic [31:0]       w_wdata [NUM_MASTERS];
  logic [3:0]        w_wstrb [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_addr[gi]  = m_addr[32*gi +: 32];
      assign w_wdata[gi] = m_wdata[32*gi +: 32];
      assign w_wstrb[gi] = m_wstrb[4*gi +: 4];
    end
  endgenerate

  // (base + offset) mod NUM_MASTERS; offset never exceeds NUM_MASTERS-1
  function automatic logic [c_GW-1:0] rr_index(input logic [c_GW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_MASTERS) begin
      sum = sum - NUM_MASTERS;
    end
    return c_GW'(sum);
  endfunction

  // First requester at or above the round-robin pointer wins
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_found && m_valid[rr_index(r_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = rr_index(r_ptr, k);
      end
    end
  end

  assign w_busy    = (r_state == BUSY);
  assign w_done    = w_busy && (s_ready || w_wd_hit);
  assign w_ptr_nxt = rr_index(r_grant, 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = BUSY;
      BUSY:    if (w_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant   <= '0;
      r_ptr     <= '0;
      r_s_instr <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
    end else if (!w_busy && w_found) begin
      r_grant   <= w_sel;
      r_s_instr <= m_instr[w_sel];
      r_s_addr  <= w_addr[w_sel];
      r_s_wdata <= w_wdata[w_sel];
      r_s_wstrb <= w_wstrb[w_sel];
    end else if (w_done) begin
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Watchdog: counter value k means k+1 BUSY cycles have elapsed this transaction
  generate
    if (TIMEOUT > 0) begin : g_watchdog
      logic [c_CNT_W-1:0] r_wd_cnt;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_wd_cnt <= '0;
        end else if (w_busy && !w_done) begin
          r_wd_cnt <= r_wd_cnt + c_CNT_W'(1);
        end else begin
          r_wd_cnt <= '0;
        end
      end

      assign w_wd_hit = w_busy && !s_ready && (r_wd_cnt == c_CNT_W'(TIMEOUT - 1));
    end else begin : g_no_watchdog
      assign w_wd_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    m_ready = '0;
    if (w_done) begin
      m_ready[r_grant] = 1'b1;
    end
  end

  // A real s_ready in the watchdog cycle keeps the slave's data and no error
  assign m_rdata     = w_wd_hit ? c_TIMEOUT_DATA : s_rdata;
  assign timeout_err = w_wd_hit;

  assign s_valid = w_busy;
  assign s_instr = r_s_instr;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_wstrb = r_s_wstrb;
  assign grant   = r_grant;

endmodule
`default_nettype wire

// File: doc/mem_native_arbiter.md
Name: mem_native_arbiter

Overview:
- Shares one native-interface memory port between NUM_MASTERS requesters, e.g. a second picorv32 core or a DMA engine alongside the main core.
- Downstream it feeds the AXI adapter/memory path.
- Round-robin arbitration; one outstanding transaction at a time.
- A watchdog force-completes any transaction the slave never acknowledges.

Parameters:
NUM_MASTERS, 2, number of upstream requesters (2..8)
TIMEOUT, 1024, BUSY cycles without s_ready before forced completion; 0 disables the watchdog

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
m_valid  in  NUM_MASTERS  per-master request
m_instr  in  NUM_MASTERS  per-master instruction-fetch flag
m_addr  in  32*NUM_MASTERS  per-master address; master i uses [32i+31:32i]
m_wdata  in  32*NUM_MASTERS  per-master write data
m_wstrb  in  4*NUM_MASTERS  per-master byte strobes; 0 means read
m_ready  out  NUM_MASTERS  per-master completion pulse
m_rdata  out  32  read data, broadcast to all masters
s_valid  out  1  downstream request
s_instr  out  1  latched instr flag
s_addr  out  32  latched address
s_wdata  out  32  latched write data
s_wstrb  out  4  latched strobes
s_ready  in  1  downstream completion
s_rdata  in  32  downstream read data
grant  out  $clog2(NUM_MASTERS) (min 1)  index of current/last granted master
timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; s_valid=0; s_addr/s_wdata/s_wstrb/s_instr=0.
  - grant=0; rr pointer=0 (master 0 highest priority); m_ready=0; timeout_err=0; watchdog counter=0.
- States IDLE, BUSY.
- IDLE:
  - If any m_valid: choose the first set bit scanning from ptr upward, modulo NUM_MASTERS.
  - On that clk edge: latch grant and the master's addr/wdata/wstrb/instr into s_*; go BUSY.
  - s_valid is a register that is 1 exactly while in BUSY.
- BUSY:
  - s_* are held constant.
  - m_ready[grant] = s_ready (combinational, same cycle); all other m_ready bits are 0.
  - m_rdata = s_rdata (combinational, always).
  - On s_ready: go IDLE; ptr = grant+1 mod NUM_MASTERS; counter cleared.
- Latency:
  - Request seen at cycle 0; s_valid=1 from cycle 1.
  - With zero-wait slave, m_ready at cycle 1.
  - Back-to-back requests always see one IDLE cycle between transactions.
- Watchdog (TIMEOUT>0):
  - Counter increments each BUSY cycle without s_ready.
  - When counter reaches TIMEOUT-1 and s_ready is still 0: m_ready[grant]=1, m_rdata forced to 32'hDEADBEEF, timeout_err=1, go IDLE, ptr advances.
  - If s_ready arrives in that same cycle, s_ready wins: normal completion, no error.
- Simultaneous requests: only one grant per IDLE cycle; losers hold m_valid and are served in rotation. No starvation: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
- Master dropping m_valid while granted is illegal upstream. The block still completes the latched transaction and does not check for this.
- m_valid of the granted master is ignored in BUSY; no re-arbitration until IDLE.
- Reset mid-BUSY: s_valid drops immediately (async); the downstream in-flight transaction is abandoned. Downstream is assumed to be reset together.
- grant holds its value in IDLE until the next arbitration.

Test Plan:
- Single master: m_valid=01, addr 0x100, wstrb 0, slave ready after 3 cycles returning 0x12345678 -> s_valid high cycles 1-3; m_ready[0] pulse at cycle 3 with m_rdata=0x12345678; grant=0.
- Contention after reset: both m_valid high, zero-wait slave -> order m0,m1,m0,m1; one IDLE cycle between each; s_addr matches the granted master.
- Write pass-through: m1 writes 0xCAFEF00D to 0x1000_0000 with wstrb 1111, instr=0 -> s_wdata/s_wstrb/s_addr latched exactly; only m_ready[1] pulses.
- Timeout: TIMEOUT=16, slave never ready -> m_ready pulses at BUSY cycle 16 with m_rdata=0xDEADBEEF; timeout_err one-cycle pulse; next request is served normally.
- Timeout tie: s_ready on cycle 16 with s_rdata=0x5 -> m_rdata=0x5 and timeout_err=0.
- Reset mid-BUSY: assert resetn=0 between clock edges -> s_valid=0 immediately; after release, m0 has priority.
